// File: rtl/reaction_timer_sched.sv
// reaction_timer_sched
//   Timing and scoring scheduler for the reaction test. It provides:
//   - a pseudo-random pre-stimulus wait of RWAIT_MIN_MS plus 0..2047 ms
//   - a fixed penalty wait of WAIT5_MS ms
//   - a millisecond reaction timer with a late flag
//   - a four-trial score history: last, best and average
//   Both waits count ticks from one shared, free-running ms prescaler. The
//   reaction timer has its own prescaler so that its count is exact.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   start_rwait    level, random wait requested      -> rwait_done
//   start_wait5    level, penalty wait requested     -> wait5_done
//   time_clr       clears the reaction timer (wins over time_en)
//   time_en        reaction timer count enable       -> rt_ms, time_late
//   rs_en          result shown; rising edge commits rt_ms as one trial
//   clr_stats      one-cycle pulse, clears the history (wins over a commit)
//   last_ms, best_ms, avg_ms, avg_valid, trial_cnt   score outputs
module reaction_timer_sched #(
  parameter int MS_DIV       = 100000,
  parameter int RWAIT_MIN_MS = 1000,
  parameter int WAIT5_MS     = 5000,
  parameter int LATE_MS      = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_rwait,
  input  logic        start_wait5,
  input  logic        time_clr,
  input  logic        time_en,
  input  logic        rs_en,
  input  logic        clr_stats,
  output logic        rwait_done,
  output logic        wait5_done,
  output logic        time_late,
  output logic [13:0] rt_ms,
  output logic [13:0] last_ms,
  output logic [13:0] best_ms,
  output logic [13:0] avg_ms,
  output logic        avg_valid,
  output logic [3:0]  trial_cnt
);

  localparam int            PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(MS_DIV - 1);
  localparam logic [13:0]   RT_MAX = 14'h3FFF;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [PW-1:0]    wpre_q, wpre_d;
  logic [PW-1:0]    tpre_q, tpre_d;
  logic [13:0]      rwait_cnt_q, rwait_cnt_d;
  logic [13:0]      wait5_cnt_q, wait5_cnt_d;
  logic             start_rwait_q, start_wait5_q, rs_en_q;
  logic [13:0]      rt_ms_q, rt_ms_d;
  logic             time_late_q, time_late_d;
  logic [13:0]      last_ms_q, last_ms_d;
  logic [13:0]      best_ms_q, best_ms_d;
  logic [13:0]      avg_ms_q, avg_ms_d;
  logic             avg_valid_q, avg_valid_d;
  logic [3:0]       trial_cnt_q, trial_cnt_d;
  logic [3:0][13:0] hist_q, hist_d;
  logic [15:0]      sum_q, sum_d;

  logic wait_tick, rwait_rise, wait5_rise, commit;

  always_comb begin
    wait_tick  = (wpre_q == PS_MAX);
    rwait_rise = start_rwait & ~start_rwait_q;
    wait5_rise = start_wait5 & ~start_wait5_q;
    commit     = rs_en & ~rs_en_q;

    // Galois LFSR, right shift; the seed is non-zero so it never locks up
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    wpre_d = wait_tick ? '0 : wpre_q + 1'b1;

    rwait_cnt_d = rwait_cnt_q;
    if (rwait_rise)
      rwait_cnt_d = 14'(RWAIT_MIN_MS) + {3'b000, lfsr_q[10:0]};
    else if (start_rwait && (rwait_cnt_q != '0) && wait_tick)
      rwait_cnt_d = rwait_cnt_q - 14'd1;

    wait5_cnt_d = wait5_cnt_q;
    if (wait5_rise)
      wait5_cnt_d = 14'(WAIT5_MS);
    else if (start_wait5 && (wait5_cnt_q != '0) && wait_tick)
      wait5_cnt_d = wait5_cnt_q - 14'd1;

    tpre_d  = tpre_q;
    rt_ms_d = rt_ms_q;
    if (time_clr) begin
      tpre_d  = '0;
      rt_ms_d = '0;
    end else if (time_en) begin
      if (tpre_q == PS_MAX) begin
        tpre_d = '0;
        if (rt_ms_q != RT_MAX)
          rt_ms_d = rt_ms_q + 14'd1;
      end else begin
        tpre_d = tpre_q + 1'b1;
      end
    end
    time_late_d = time_clr ? 1'b0 : (rt_ms_q >= 14'(LATE_MS));

    hist_d      = hist_q;
    sum_d       = sum_q;
    last_ms_d   = last_ms_q;
    best_ms_d   = best_ms_q;
    trial_cnt_d = trial_cnt_q;
    if (clr_stats) begin
      hist_d      = '0;
      sum_d       = '0;
      last_ms_d   = '0;
      best_ms_d   = RT_MAX;
      trial_cnt_d = '0;
    end else if (commit) begin
      last_ms_d = rt_ms_q;
      best_ms_d = (rt_ms_q < best_ms_q) ? rt_ms_q : best_ms_q;
      hist_d    = {hist_q[2:0], rt_ms_q};
      // running sum of the window; cleared entries are zero so the first
      // three commits need no special case
      sum_d = sum_q + {2'b00, rt_ms_q} - {2'b00, hist_q[3]};
      if (trial_cnt_q != 4'd15)
        trial_cnt_d = trial_cnt_q + 4'd1;
    end
    // average is taken from the next-state sum so it lands with last_ms
    avg_valid_d = (trial_cnt_d >= 4'd4);
    avg_ms_d    = avg_valid_d ? sum_d[15:2] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q        <= 16'hACE1;
      wpre_q        <= '0;
      tpre_q        <= '0;
      rwait_cnt_q   <= '0;
      wait5_cnt_q   <= '0;
      start_rwait_q <= 1'b0;
      start_wait5_q <= 1'b0;
      rs_en_q       <= 1'b0;
      rt_ms_q       <= '0;
      time_late_q   <= 1'b0;
      last_ms_q     <= '0;
      best_ms_q     <= RT_MAX;
      avg_ms_q      <= '0;
      avg_valid_q   <= 1'b0;
      trial_cnt_q   <= '0;
      hist_q        <= '0;
      sum_q         <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      wpre_q        <= wpre_d;
      tpre_q        <= tpre_d;
      rwait_cnt_q   <= rwait_cnt_d;
      wait5_cnt_q   <= wait5_cnt_d;
      start_rwait_q <= start_rwait;
      start_wait5_q <= start_wait5;
      rs_en_q       <= rs_en;
      rt_ms_q       <= rt_ms_d;
      time_late_q   <= time_late_d;
      last_ms_q     <= last_ms_d;
      best_ms_q     <= best_ms_d;
      avg_ms_q      <= avg_ms_d;
      avg_valid_q   <= avg_valid_d;
      trial_cnt_q   <= trial_cnt_d;
      hist_q        <= hist_d;
      sum_q         <= sum_d;
    end
  end

  // In the cycle the request rises the counter still holds zero from the
  // previous wait (or reset); the registered request masks that stale zero.
  assign rwait_done = start_rwait & start_rwait_q & (rwait_cnt_q == '0);
  assign wait5_done = start_wait5 & start_wait5_q & (wait5_cnt_q == '0);

  assign time_late = time_late_q;
  assign rt_ms     = rt_ms_q;
  assign last_ms   = last_ms_q;
  assign best_ms   = best_ms_q;
  assign avg_ms    = avg_ms_q;
  assign avg_valid = avg_valid_q;
  assign trial_cnt = trial_cnt_q;

endmodule

// File: tb/tb_reaction_timer_sched.sv
module tb_reaction_timer_sched;

  localparam int D    = 10;
  localparam int RMIN = 100;
  localparam int W5   = 500;
  localparam int LATE = 20;

  logic clk = 1'b0, rst = 1'b1;
  logic start_rwait = 1'b0, start_wait5 = 1'b0, time_clr = 1'b0, time_en = 1'b0;
  logic rs_en = 1'b0, clr_stats = 1'b0;
  logic rwait_done, wait5_done, time_late, avg_valid;
  logic [13:0] rt_ms, last_ms, best_ms, avg_ms;
  logic [3:0] trial_cnt;

  reaction_timer_sched #(.MS_DIV(D), .RWAIT_MIN_MS(RMIN), .WAIT5_MS(W5), .LATE_MS(LATE)) dut (
    .clk(clk), .rst(rst), .start_rwait(start_rwait), .start_wait5(start_wait5),
    .time_clr(time_clr), .time_en(time_en), .rs_en(rs_en), .clr_stats(clr_stats),
    .rwait_done(rwait_done), .wait5_done(wait5_done), .time_late(time_late),
    .rt_ms(rt_ms), .last_ms(last_ms), .best_ms(best_ms), .avg_ms(avg_ms),
    .avg_valid(avg_valid), .trial_cnt(trial_cnt));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference LFSR: seeded while rst is high, one Galois step per cycle otherwise
  logic [15:0] lfsr_m = 16'h0000;
  always @(posedge clk)
    lfsr_m <= rst ? 16'hACE1 : (lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1));

  typedef struct { int stamp; int kind; int v0; int v1; int v2; int v3; int v4; } exp_t;
  typedef struct { int lo; int hi; } win_t;
  exp_t sb_q[$];
  win_t rw_win[$], w5_win[$];
  bit rw_seen = 0, w5_seen = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(string name, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got cycle %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void push(int st, int k, int a, int b, int c = 0, int d = 0, int e = 0);
    exp_t x;
    x.stamp = st; x.kind = k; x.v0 = a; x.v1 = b; x.v2 = c; x.v3 = d; x.v4 = e;
    sb_q.push_back(x);
  endfunction

  // scoreboard monitor: compares every expectation due at this cycle
  always @(negedge clk) begin : mon
    int i;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].stamp <= cyc) begin
        case (sb_q[i].kind)
          0: begin
            chk("rt_ms", int'(rt_ms), sb_q[i].v0);
            chk("time_late", int'(time_late), sb_q[i].v1);
          end
          1: begin
            chk("last_ms", int'(last_ms), sb_q[i].v0);
            chk("best_ms", int'(best_ms), sb_q[i].v1);
            chk("avg_ms", int'(avg_ms), sb_q[i].v2);
            chk("avg_valid", int'(avg_valid), sb_q[i].v3);
            chk("trial_cnt", int'(trial_cnt), sb_q[i].v4);
          end
          default: begin
            chk("rwait_done_level", int'(rwait_done), sb_q[i].v0);
            chk("wait5_done_level", int'(wait5_done), sb_q[i].v1);
          end
        endcase
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // wait monitor: each rising done flag must fall inside the window queued at request time
  logic rd_prev = 1'b0, w5_prev = 1'b0;
  always @(negedge clk) begin : wmon
    win_t w;
    if (rwait_done && !rd_prev) begin
      if (rw_win.size() == 0) chk("rwait_done_unexpected", 1, 0);
      else begin w = rw_win.pop_front(); chk_rng("rwait_latency", cyc, w.lo, w.hi); end
      rw_seen = 1;
    end
    if (wait5_done && !w5_prev) begin
      if (w5_win.size() == 0) chk("wait5_done_unexpected", 1, 0);
      else begin w = w5_win.pop_front(); chk_rng("wait5_latency", cyc, w.lo, w.hi); end
      w5_seen = 1;
    end
    rd_prev = rwait_done;
    w5_prev = wait5_done;
  end

  // behavioural model state
  int en_cnt = 0, rt_e = 0, late_e = 0;
  int last_e = 0, best_e = 16383, cnt_e = 0;
  int hist[$];
  bit rs_prev = 0;

  function automatic void stats_reset();
    last_e = 0; best_e = 16383; cnt_e = 0; hist.delete();
  endfunction

  function automatic void push_stats();
    int s, avg;
    s = 0;
    foreach (hist[k]) s += hist[k];
    avg = (cnt_e >= 4) ? s / 4 : 0;
    push(cyc + 1, 1, last_e, best_e, avg, (cnt_e >= 4) ? 1 : 0, cnt_e);
  endfunction

  // inputs are already set for the coming edge: predict its outcome, then step
  task automatic go();
    int rt_old;
    if (rst) begin
      en_cnt = 0; rt_e = 0; late_e = 0; rs_prev = 0;
      stats_reset();
      push_stats();
    end else begin
      rt_old = rt_e;
      if (time_clr) en_cnt = 0;
      else if (time_en) en_cnt++;
      rt_e   = (en_cnt / D > 16383) ? 16383 : en_cnt / D;
      late_e = time_clr ? 0 : ((rt_old >= LATE) ? 1 : 0);
      if (clr_stats) begin
        stats_reset();
        push_stats();
      end else if (rs_en && !rs_prev) begin
        last_e = rt_old;
        if (rt_old < best_e) best_e = rt_old;
        hist.push_front(rt_old);
        if (hist.size() > 4) void'(hist.pop_back());
        if (cnt_e < 15) cnt_e++;
        push_stats();
      end
      rs_prev = rs_en;
    end
    push(cyc + 1, 0, rt_e, late_e);
    @(posedge clk); #1;
  endtask

  task automatic raise_rwait();
    int l, e;
    l = RMIN + int'(lfsr_m[10:0]);
    e = cyc + 1;
    rw_win.push_back('{e + l * D - D, e + l * D + D});
    rw_seen = 0;
    start_rwait = 1'b1;
  endtask

  task automatic raise_wait5();
    int e;
    e = cyc + 1;
    w5_win.push_back('{e + W5 * D - D, e + W5 * D + D});
    w5_seen = 0;
    start_wait5 = 1'b1;
  endtask

  task automatic wait_flag(bit which, int bound);
    int n;
    n = 0;
    while (!(which ? w5_seen : rw_seen) && n < bound) begin
      time_en  = 1'($urandom_range(0, 1));
      time_clr = ($urandom_range(0, 63) == 0);
      go();
      n++;
    end
    time_en = 1'b0; time_clr = 1'b0;
    if (!(which ? w5_seen : rw_seen)) chk(which ? "wait5_timeout" : "rwait_timeout", 0, 1);
  endtask

  task automatic commit_trial(int ms);
    time_clr = 1'b1; time_en = 1'b0; go();
    time_clr = 1'b0; time_en = 1'b1;
    repeat (ms * D) go();
    time_en = 1'b0;
    rs_en = 1'b1; go(); go();
    rs_en = 1'b0; go();
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv[5];
    tv = '{300, 200, 400, 100, 500};
    rst = 1'b1;
    repeat (3) go();
    rst = 1'b0;
    push(cyc, 2, 0, 0);

    // reaction timer: clear then 205 enabled cycles, hold, clear again
    time_clr = 1'b1; go();
    time_clr = 1'b0; time_en = 1'b1;
    repeat (205) go();
    time_en = 1'b0;
    repeat (4) go();
    time_clr = 1'b1; go();
    time_clr = 1'b0; repeat (2) go();

    // random enable/clear pattern
    repeat (400) begin
      time_en  = 1'($urandom_range(0, 1));
      time_clr = ($urandom_range(0, 39) == 0);
      go();
    end
    time_en = 1'b0; time_clr = 1'b0; go();

    // scoring: fixed trials, then random short trials past saturation
    foreach (tv[k]) commit_trial(tv[k]);
    repeat (12) commit_trial($urandom_range(0, 30));

    // clear coincident with a commit edge, then rebuild history
    time_clr = 1'b1; go();
    time_clr = 1'b0; time_en = 1'b1; repeat (77) go(); time_en = 1'b0;
    rs_en = 1'b1; clr_stats = 1'b1; go();
    clr_stats = 1'b0; go();
    rs_en = 1'b0; go();
    commit_trial(7);
    commit_trial(3);

    // single random wait, hold after done, drop
    raise_rwait(); go();
    wait_flag(0, (RMIN + 2047) * D + 4 * D);
    push(cyc, 2, 1, 0); go();
    push(cyc, 2, 1, 0); go();
    start_rwait = 1'b0;
    push(cyc, 2, 0, 0); go();

    // overlapping penalty and random waits
    raise_wait5(); go();
    repeat ($urandom_range(0, 50)) go();
    raise_rwait(); go();
    wait_flag(0, (RMIN + 2047) * D + 4 * D);
    wait_flag(1, W5 * D + 4 * D);
    push(cyc, 2, 1, 1); go();
    start_rwait = 1'b0;
    push(cyc, 2, 0, 1); go();
    start_wait5 = 1'b0;
    push(cyc, 2, 0, 0); go();

    // reset in the middle of a random wait with the request held
    raise_rwait(); go();
    repeat (500) go();
    rst = 1'b1;
    rw_win.delete();
    go(); go();
    rst = 1'b0;
    push(cyc, 2, 0, 0);
    raise_rwait();
    go();
    push(cyc, 2, 0, 0);
    wait_flag(0, (RMIN + 2047) * D + 4 * D);
    start_rwait = 1'b0;
    push(cyc, 2, 0, 0); go();

    repeat (3) go();
    if (rw_win.size() != 0) chk("rwait_pending", rw_win.size(), 0);
    if (w5_win.size() != 0) chk("wait5_pending", w5_win.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
